// File: rtl/seg_display_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types, segment patterns and helpers for the
//               multiplexed seven-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Active-low segment vector ordered {g,f,e,d,c,b,a}
    typedef logic [6:0] seg_t;

    // Per-digit display code: hex nibble values plus two special glyphs
    typedef enum logic [4:0] {
        HEX0  = 5'd0,  HEX1 = 5'd1,  HEX2 = 5'd2,  HEX3 = 5'd3,
        HEX4  = 5'd4,  HEX5 = 5'd5,  HEX6 = 5'd6,  HEX7 = 5'd7,
        HEX8  = 5'd8,  HEX9 = 5'd9,  HEXA = 5'd10, HEXB = 5'd11,
        HEXC  = 5'd12, HEXD = 5'd13, HEXE = 5'd14, HEXF = 5'd15,
        BLANK = 5'd16,
        DASH  = 5'd17
    } digit_t;

    localparam seg_t c_seg_0     = 7'b1000000;
    localparam seg_t c_seg_1     = 7'b1111001;
    localparam seg_t c_seg_2     = 7'b0100100;
    localparam seg_t c_seg_3     = 7'b0110000;
    localparam seg_t c_seg_4     = 7'b0011001;
    localparam seg_t c_seg_5     = 7'b0010010;
    localparam seg_t c_seg_6     = 7'b0000010;
    localparam seg_t c_seg_7     = 7'b1111000;
    localparam seg_t c_seg_8     = 7'b0000000;
    localparam seg_t c_seg_9     = 7'b0010000;
    localparam seg_t c_seg_a     = 7'b0001000;
    localparam seg_t c_seg_b     = 7'b0000011;
    localparam seg_t c_seg_c     = 7'b1000110;
    localparam seg_t c_seg_d     = 7'b0100001;
    localparam seg_t c_seg_e     = 7'b0000110;
    localparam seg_t c_seg_f     = 7'b0001110;
    localparam seg_t c_seg_blank = 7'b1111111;
    localparam seg_t c_seg_dash  = 7'b0111111;

    // 10^n, used to derive the largest decimal value that fits the digit bank
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_mux_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decoder
// Description : Combinational digit-code to active-low segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decoder
    import seg_pkg::*;
(
    input  digit_t i_code,
    output seg_t   o_seg
);

    // Map each digit code onto its glyph; unknown codes render blank
    always_comb begin
        o_seg = c_seg_blank;
        case (i_code)
            HEX0:    o_seg = c_seg_0;
            HEX1:    o_seg = c_seg_1;
            HEX2:    o_seg = c_seg_2;
            HEX3:    o_seg = c_seg_3;
            HEX4:    o_seg = c_seg_4;
            HEX5:    o_seg = c_seg_5;
            HEX6:    o_seg = c_seg_6;
            HEX7:    o_seg = c_seg_7;
            HEX8:    o_seg = c_seg_8;
            HEX9:    o_seg = c_seg_9;
            HEXA:    o_seg = c_seg_a;
            HEXB:    o_seg = c_seg_b;
            HEXC:    o_seg = c_seg_c;
            HEXD:    o_seg = c_seg_d;
            HEXE:    o_seg = c_seg_e;
            HEXF:    o_seg = c_seg_f;
            DASH:    o_seg = c_seg_dash;
            default: o_seg = c_seg_blank;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_mux
// Description : Time-multiplexed seven-segment driver. Converts a loaded
//               binary word to decimal (shift-add-3) or hex digits, handles
//               leading-zero blanking and overflow, and scans the digit bank.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    input  logic              hex_mode,
    input  logic              blank_lz,
    output logic              busy,
    output logic              ovf,
    output seg_t              seg,
    output logic [DIGITS-1:0] an
);

    localparam int c_bcd_w  = 4 * DIGITS;
    localparam int c_idx_w  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_pre_w  = $clog2(SCAN_DIV);
    localparam int c_cnt_w  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [63:0]        c_dec_limit = pow10(DIGITS);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_pre_w-1:0] c_pre_last  = c_pre_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_an_reset  = ~DIGITS'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_ovf;
    logic [WIDTH-1:0]         r_value;
    logic [WIDTH-1:0]         r_shift;
    logic [c_bcd_w-1:0]       r_bcd;
    logic [c_cnt_w-1:0]       r_cnt;
    logic                     r_hex;
    logic                     r_blz;
    logic [DIGITS-1:0][4:0]   r_disp;
    logic [c_pre_w-1:0]       r_presc;
    logic [c_idx_w-1:0]       r_idx;
    seg_t                     r_seg;
    logic [DIGITS-1:0]        r_an;

    logic [c_bcd_w-1:0]       w_bcd_next;
    logic [3:0]               w_nib;
    logic [c_bcd_w-1:0]       w_hex_src;
    logic                     w_hex_ovf;
    logic                     w_dec_ovf;
    logic                     w_ovf;
    logic                     w_run;
    digit_t                   w_code;
    logic [DIGITS-1:0][4:0]   w_disp_next;
    digit_t                   w_sel;
    seg_t                     w_seg_dec;
    logic [DIGITS-1:0]        w_an_next;

    // Hex source nibbles: zero-pad or truncate the latched value to the bank,
    // bits beyond the bank feed the hex overflow flag
    generate
        if (c_bcd_w > WIDTH) begin : g_hex_pad
            assign w_hex_src = {{(c_bcd_w - WIDTH){1'b0}}, r_value};
            assign w_hex_ovf = 1'b0;
        end else if (c_bcd_w == WIDTH) begin : g_hex_exact
            assign w_hex_src = r_value;
            assign w_hex_ovf = 1'b0;
        end else begin : g_hex_trunc
            assign w_hex_src = r_value[c_bcd_w-1:0];
            assign w_hex_ovf = |r_value[WIDTH-1:c_bcd_w];
        end
    endgenerate

    assign w_dec_ovf = (64'(r_value) >= c_dec_limit);
    assign w_ovf     = r_hex ? w_hex_ovf : w_dec_ovf;

    // One shift-add-3 step: correct every BCD nibble >= 5, then shift left
    // pulling in the next binary MSB; the top nibble's carry is discarded
    always_comb begin
        w_bcd_next    = '0;
        w_nib         = '0;
        w_bcd_next[0] = r_shift[WIDTH-1];
        for (int d = 0; d < DIGITS; d++) begin
            w_nib = r_bcd[4*d +: 4];
            if (w_nib >= 4'd5) begin
                w_nib = w_nib + 4'd3;
            end
            w_bcd_next[4*d+1 +: 3] = w_nib[2:0];
            if (d != DIGITS - 1) begin
                w_bcd_next[4*d+4] = w_nib[3];
            end
        end
    end

    // Digit codes to commit at the end of conversion: blank leading zeros
    // from the top down (digit 0 always shown), dashes override on overflow
    always_comb begin
        w_disp_next = {DIGITS{BLANK}};
        w_run       = r_blz;
        w_code      = BLANK;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (r_hex) begin
                w_code = digit_t'({1'b0, w_hex_src[4*d +: 4]});
            end else begin
                w_code = digit_t'({1'b0, w_bcd_next[4*d +: 4]});
            end
            if (w_run && (d != 0) && (w_code == HEX0)) begin
                w_code = BLANK;
            end else begin
                w_run = 1'b0;
            end
            if (w_ovf) begin
                w_code = DASH;
            end
            w_disp_next[d] = w_code;
        end
    end

    // Conversion FSM: latch on load, iterate, then commit display and ovf at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_value <= '0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_hex   <= 1'b0;
            r_blz   <= 1'b0;
            r_disp  <= {DIGITS{BLANK}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_value <= value;
                        r_shift <= value;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_hex   <= hex_mode;
                        r_blz   <= blank_lz;
                        r_busy  <= 1'b1;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (r_hex || (r_cnt == c_cnt_last)) begin
                        r_disp  <= w_disp_next;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_bcd   <= w_bcd_next;
                        r_shift <= r_shift << 1;
                        r_cnt   <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Refresh prescaler and scan index; index advances on prescaler terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == c_pre_last) begin
            r_presc <= '0;
            r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
        end else begin
            r_presc <= r_presc + c_pre_w'(1);
        end
    end

    assign w_sel = digit_t'(r_disp[r_idx]);

    seg_hex_decoder u_decoder (
        .i_code (w_sel),
        .o_seg  (w_seg_dec)
    );

    // One-hot-low enable for the currently selected digit
    always_comb begin
        w_an_next        = '1;
        w_an_next[r_idx] = 1'b0;
    end

    // Register seg/an together so digit changes never glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= c_seg_blank;
            r_an  <= c_an_reset;
        end else begin
            r_seg <= w_seg_dec;
            r_an  <= w_an_next;
        end
    end

    assign busy = r_busy;
    assign ovf  = r_ovf;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_mux
// Description : Self-checking bench for seg_display_mux with a cycle model
//               feeding an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_mux;

    localparam int WIDTH    = 16;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic [WIDTH-1:0] value    = '0;
    logic             load     = 1'b0;
    logic             hex_mode = 1'b0;
    logic             blank_lz = 1'b0;
    logic             busy;
    logic             ovf;
    logic [6:0]       seg;
    logic [3:0]       an;

    seg_display_mux #(
        .WIDTH    (WIDTH),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .busy     (busy),
        .ovf      (ovf),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       ovf;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] c_pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_busy;
    int         m_cnt;
    logic       m_ovf;
    logic [6:0] m_disp [DIGITS];
    int         m_idx;
    int         m_presc;
    longint     m_val;
    bit         m_hex;
    bit         m_blz;

    function automatic bit model_ovf(input longint v, input bit hx);
        longint lim;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        return hx ? ((v >> (4 * DIGITS)) != 0) : (v >= lim);
    endfunction

    function automatic logic [6:0] model_digit(input longint v, input bit hx, input bit blz, input int d);
        longint base;
        longint pw;
        base = hx ? 16 : 10;
        pw   = 1;
        for (int i = 0; i < d; i++) pw = pw * base;
        if (model_ovf(v, hx)) return 7'b0111111;
        if (blz && d > 0 && v < pw) return 7'b1111111;
        return c_pat[int'((v / pw) % base)];
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_idx   = 0;
        m_presc = 0;
        for (int d = 0; d < DIGITS; d++) m_disp[d] = 7'b1111111;
        q.delete();
    endtask

    task automatic model_step();
        exp_t e;
        e.seg = m_disp[m_idx];
        e.an  = ~4'(1 << m_idx);
        if (m_presc == SCAN_DIV - 1) begin
            m_presc = 0;
            m_idx   = (m_idx + 1) % DIGITS;
        end else begin
            m_presc++;
        end
        if (!m_busy) begin
            if (load) begin
                m_val  = longint'(value);
                m_hex  = hex_mode;
                m_blz  = blank_lz;
                m_busy = 1'b1;
                m_cnt  = hex_mode ? 1 : WIDTH;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                m_ovf  = model_ovf(m_val, m_hex);
                for (int d = 0; d < DIGITS; d++) m_disp[d] = model_digit(m_val, m_hex, m_blz, d);
            end
        end
        e.busy = m_busy;
        e.ovf  = m_ovf;
        q.push_back(e);
    endtask

    // Model advances on every active edge, pushing the outputs it predicts
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // Checker pops one expectation per cycle on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_ovf",  32'(ovf),  32'd0);
                check("rst_seg",  32'(seg),  32'h7F);
                check("rst_an",   32'(an),   32'hE);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                check("busy", 32'(busy), 32'(e.busy));
                check("ovf",  32'(ovf),  32'(e.ovf));
                check("an",   32'(an),   32'(e.an));
                check("seg",  32'(seg),  32'(e.seg));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v, input bit hx, input bit blz, input int run);
        wait_idle();
        value    = v;
        hex_mode = hx;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (run) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        do_load(16'd1234,  1'b0, 1'b0, 36);
        do_load(16'hBEEF,  1'b1, 1'b0, 20);
        do_load(16'd7,     1'b0, 1'b1, 36);
        do_load(16'd0,     1'b0, 1'b1, 36);
        do_load(16'd12345, 1'b0, 1'b0, 36);
        do_load(16'd42,    1'b0, 1'b0, 36);

        // second load five cycles into a conversion must be dropped
        do_load(16'd1234,  1'b0, 1'b0, 4);
        value = 16'd9876;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (36) @(negedge clk);

        // back-to-back: next load lands in the cycle busy falls
        do_load(16'd321,   1'b0, 1'b0, 0);
        do_load(16'h00A5,  1'b1, 1'b1, 20);

        // asynchronous reset mid-conversion
        do_load(16'd4321,  1'b0, 1'b0, 6);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_seg",  32'(seg),  32'h7F);
        check("async_an",   32'(an),   32'hE);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        do_load(16'd56,    1'b0, 1'b1, 36);

        for (int i = 0; i < 6; i++) begin
            do_load(WIDTH'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 36);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
